// File: rtl/sb_trans_gen_param.sv
// Sideband transaction generator: serialises AT and LT transactions
// into 10-bit symbols held for SYM_CYCLES clocks each.
module sb_trans_gen_param #(
  parameter int MAX_LEN    = 8,
  parameter int SYM_CYCLES = 10
) (
  input  logic                 sb_clk,
  input  logic                 rst,
  input  logic [2:0]           trans_sel,
  input  logic [7:0]           trans_addr,
  input  logic [6:0]           trans_len,
  input  logic [8*MAX_LEN-1:0] trans_data,
  input  logic [7:0]           lt_byte,
  input  logic [15:0]          crc_in,
  input  logic                 disconnect_sbtx,
  input  logic                 tdisconnect_tx_min,
  output logic [9:0]           trans,
  output logic [1:0]           trans_state,
  output logic                 crc_en,
  output logic                 crc_clr,
  output logic                 busy,
  output logic                 trans_sent,
  output logic                 trans_err,
  output logic                 disconnected_s
);

  typedef enum logic [3:0] {
    S_DISC, S_IDLE, S_DLE1, S_STX, S_ADDR, S_LEN, S_DATA,
    S_CRC_LO, S_CRC_HI, S_DLE2, S_ETX, S_LSE, S_CLSE
  } state_e;

  localparam int CW = $clog2(SYM_CYCLES);
  localparam logic [CW-1:0] SYM_LAST = CW'(SYM_CYCLES - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
  localparam logic [7:0] DLE = 8'hFE;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 stuff_q, stuff_d;
  logic [6:0]           idx_q, idx_d;
  logic [2:0]           sel_q, sel_d;
  logic [7:0]           addr_q, addr_d;
  logic [6:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] data_q, data_d;
  logic [7:0]           lt_q, lt_d;
  logic [15:0]          crc_q, crc_d;

  logic [9:0] trans_q, trans_d;
  logic [1:0] tstate_q, tstate_d;
  logic       crc_en_q, crc_en_d;
  logic       crc_clr_q, crc_clr_d;
  logic       busy_q, busy_d;
  logic       sent_q, sent_d;
  logic       err_q, err_d;
  logic       disc_q, disc_d;

  logic [7:0] cur_dbyte, nxt_dbyte;
  logic [7:0] cur_byte, nxt_byte;
  logic       adv, has_data, is_lt, stuffable;

  function automatic logic [7:0] sym_byte(
    input state_e      s,
    input logic [2:0]  sel,
    input logic [7:0]  addr,
    input logic [6:0]  len,
    input logic [7:0]  dbyte,
    input logic [15:0] crc,
    input logic [7:0]  lt
  );
    logic [7:0] b;
    b = DLE;
    unique case (s)
      S_STX:    b = (sel == 3'd1 || sel == 3'd2) ? 8'h05 : 8'h04;
      S_ADDR:   b = addr;
      S_LEN:    b = {(sel == 3'd2 || sel == 3'd4), len};
      S_DATA:   b = dbyte;
      S_CRC_LO: b = crc[7:0];
      S_CRC_HI: b = crc[15:8];
      S_ETX:    b = 8'h40;
      S_LSE:    b = lt;
      S_CLSE:   b = ~lt;
      default:  b = DLE;
    endcase
    return b;
  endfunction

  always_comb begin
    cur_dbyte = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_q == 7'(i)) cur_dbyte = data_q[8*i +: 8];
  end

  always_comb begin
    nxt_dbyte = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (idx_d == 7'(i)) nxt_dbyte = data_q[8*i +: 8];
  end

  assign adv      = (cnt_q == SYM_LAST);
  assign has_data = (sel_q == 3'd2) || (sel_q == 3'd3);
  assign is_lt    = (sel_q == 3'd5);
  assign cur_byte = sym_byte(state_q, sel_q, addr_q, len_q,
                             cur_dbyte, crc_q, lt_q);
  assign stuffable = state_q inside {S_ADDR, S_LEN, S_DATA,
                                     S_CRC_LO, S_CRC_HI};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stuff_d = stuff_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    data_d  = data_q;
    lt_d    = lt_q;
    crc_d   = crc_q;
    err_d   = 1'b0;
    sent_d  = 1'b0;
    if (disconnect_sbtx) begin
      state_d = S_DISC;
      cnt_d   = '0;
      stuff_d = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_DISC: if (tdisconnect_tx_min) state_d = S_IDLE;
        S_IDLE: begin
          if (trans_sel inside {[3'd1:3'd5]}) begin
            if (trans_sel != 3'd5 && trans_len > LEN_MAX) begin
              err_d = 1'b1;
            end else begin
              state_d = S_DLE1;
              cnt_d   = '0;
              stuff_d = 1'b0;
              idx_d   = '0;
              sel_d   = trans_sel;
              addr_d  = trans_addr;
              len_d   = trans_len;
              data_d  = trans_data;
              lt_d    = lt_byte;
            end
          end
        end
        default: begin
          if (!adv) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d = '0;
            // a 0xFE payload byte is repeated once before moving on
            if (!stuff_q && stuffable && cur_byte == DLE) begin
              stuff_d = 1'b1;
            end else begin
              stuff_d = 1'b0;
              unique case (state_q)
                S_DLE1: state_d = is_lt ? S_LSE : S_STX;
                S_STX:  state_d = S_ADDR;
                S_ADDR: state_d = S_LEN;
                S_LEN: begin
                  if (has_data && len_q != 7'd0) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                  end else begin
                    state_d = S_CRC_LO;
                    crc_d   = crc_in;
                  end
                end
                S_DATA: begin
                  if (idx_q == len_q - 7'd1) begin
                    state_d = S_CRC_LO;
                    crc_d   = crc_in;
                  end else begin
                    idx_d = idx_q + 7'd1;
                  end
                end
                S_CRC_LO: state_d = S_CRC_HI;
                S_CRC_HI: state_d = S_DLE2;
                S_DLE2:   state_d = S_ETX;
                S_ETX: begin
                  state_d = S_IDLE;
                  sent_d  = 1'b1;
                end
                S_LSE:    state_d = S_CLSE;
                S_CLSE: begin
                  state_d = S_IDLE;
                  sent_d  = 1'b1;
                end
                default:  state_d = S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign nxt_byte = sym_byte(state_d, sel_q, addr_q, len_q,
                             nxt_dbyte, crc_d, lt_q);

  always_comb begin
    trans_d   = {1'b1, (stuff_d ? DLE : nxt_byte), 1'b0};
    tstate_d  = 2'd2;
    busy_d    = 1'b1;
    disc_d    = 1'b0;
    crc_en_d  = !stuff_d &&
                (state_d inside {S_STX, S_ADDR, S_LEN, S_DATA});
    crc_clr_d = (state_q == S_IDLE) && (state_d == S_DLE1) &&
                (sel_d != 3'd5);
    unique case (state_d)
      S_DISC: begin
        trans_d  = 10'h000;
        tstate_d = 2'd0;
        busy_d   = 1'b0;
        disc_d   = 1'b1;
      end
      S_IDLE: begin
        trans_d  = 10'h3FF;
        tstate_d = 2'd1;
        busy_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q   <= S_DISC;
      cnt_q     <= '0;
      stuff_q   <= 1'b0;
      idx_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      data_q    <= '0;
      lt_q      <= '0;
      crc_q     <= '0;
      trans_q   <= 10'h000;
      tstate_q  <= 2'd0;
      crc_en_q  <= 1'b0;
      crc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      sent_q    <= 1'b0;
      err_q     <= 1'b0;
      disc_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stuff_q   <= stuff_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      data_q    <= data_d;
      lt_q      <= lt_d;
      crc_q     <= crc_d;
      trans_q   <= trans_d;
      tstate_q  <= tstate_d;
      crc_en_q  <= crc_en_d;
      crc_clr_q <= crc_clr_d;
      busy_q    <= busy_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
      disc_q    <= disc_d;
    end
  end

  assign trans          = trans_q;
  assign trans_state    = tstate_q;
  assign crc_en         = crc_en_q;
  assign crc_clr        = crc_clr_q;
  assign busy           = busy_q;
  assign trans_sent     = sent_q;
  assign trans_err      = err_q;
  assign disconnected_s = disc_q;

endmodule

// File: tb/tb_sb_trans_gen_param.sv
// Directed bench for sb_trans_gen_param with a symbol scoreboard.
module tb_sb_trans_gen_param;

  localparam int ML  = 8;
  localparam int SYM = 10;

  logic          sb_clk = 1'b0;
  logic          rst;
  logic [2:0]    trans_sel;
  logic [7:0]    trans_addr;
  logic [6:0]    trans_len;
  logic [8*ML-1:0] trans_data;
  logic [7:0]    lt_byte;
  logic [15:0]   crc_in;
  logic          disconnect_sbtx;
  logic          tdisconnect_tx_min;
  logic [9:0]    trans;
  logic [1:0]    trans_state;
  logic          crc_en, crc_clr, busy;
  logic          trans_sent, trans_err, disconnected_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       en;
    logic       clr;
    logic       scr;
  } ent_t;

  ent_t sb[$];

  sb_trans_gen_param #(.MAX_LEN(ML), .SYM_CYCLES(SYM)) dut (
    .sb_clk(sb_clk),
    .rst(rst),
    .trans_sel(trans_sel),
    .trans_addr(trans_addr),
    .trans_len(trans_len),
    .trans_data(trans_data),
    .lt_byte(lt_byte),
    .crc_in(crc_in),
    .disconnect_sbtx(disconnect_sbtx),
    .tdisconnect_tx_min(tdisconnect_tx_min),
    .trans(trans),
    .trans_state(trans_state),
    .crc_en(crc_en),
    .crc_clr(crc_clr),
    .busy(busy),
    .trans_sent(trans_sent),
    .trans_err(trans_err),
    .disconnected_s(disconnected_s)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic en,
                      input logic clr, input logic scr);
    ent_t e;
    e.b = b; e.en = en; e.clr = clr; e.scr = scr;
    sb.push_back(e);
  endtask

  task automatic pushs(input logic [7:0] b, input logic en,
                       input logic scr);
    push(b, en, 1'b0, scr);
    if (b == 8'hFE) push(8'hFE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model(input logic [2:0] sel, input logic [7:0] addr,
                       input logic [6:0] len, input logic [8*ML-1:0] d,
                       input logic [7:0] lt, input logic [15:0] crc);
    if (sel == 3'd5) begin
      push(8'hFE, 1'b0, 1'b0, 1'b0);
      push(lt, 1'b0, 1'b0, 1'b0);
      push(~lt, 1'b0, 1'b0, 1'b0);
    end else begin
      push(8'hFE, 1'b0, 1'b1, 1'b0);
      push((sel <= 3'd2) ? 8'h05 : 8'h04, 1'b1, 1'b0, 1'b0);
      pushs(addr, 1'b1, 1'b0);
      pushs({(sel == 3'd2 || sel == 3'd4), len}, 1'b1, 1'b0);
      if (sel == 3'd2 || sel == 3'd3)
        for (int i = 0; i < int'(len); i++)
          pushs(d[8*i +: 8], 1'b1, 1'b0);
      pushs(crc[7:0], 1'b0, 1'b1);
      pushs(crc[15:8], 1'b0, 1'b0);
      push(8'hFE, 1'b0, 1'b0, 1'b0);
      push(8'h40, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic start(input logic [2:0] sel, input logic [7:0] addr,
                       input logic [6:0] len, input logic [8*ML-1:0] d,
                       input logic [7:0] lt, input logic [15:0] crc);
    trans_sel  = sel;
    trans_addr = addr;
    trans_len  = len;
    trans_data = d;
    lt_byte    = lt;
    crc_in     = crc;
    model(sel, addr, len, d, lt, crc);
    step();
    trans_sel = 3'd0;
  endtask

  task automatic play(input int n);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e = sb.pop_front();
      for (int c = 0; c < SYM; c++) begin
        chk("trans", 16'(trans), 16'({1'b1, e.b, 1'b0}));
        chk("crc_en", 16'(crc_en), 16'(e.en));
        chk("crc_clr", 16'(crc_clr), 16'(e.clr && c == 0));
        chk("busy", 16'(busy), 16'd1);
        chk("tstate", 16'(trans_state), 16'd2);
        chk("sent_early", 16'(trans_sent), 16'd0);
        chk("err_busy", 16'(trans_err), 16'd0);
        // captured CRC must survive a change of crc_in
        if (e.scr && c == 0) crc_in = 16'h0BAD;
        step();
      end
    end
  endtask

  task automatic done();
    chk("sent", 16'(trans_sent), 16'd1);
    chk("idle_trans", 16'(trans), 16'h3FF);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_tstate", 16'(trans_state), 16'd1);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    step();
    chk("sent_pulse", 16'(trans_sent), 16'd0);
    chk("idle_trans2", 16'(trans), 16'h3FF);
  endtask

  initial begin
    rst = 1'b1;
    trans_sel = '0; trans_addr = '0; trans_len = '0;
    trans_data = '0; lt_byte = '0; crc_in = '0;
    disconnect_sbtx = 1'b0;
    tdisconnect_tx_min = 1'b1;
    step(); step();
    chk("rst_trans", 16'(trans), 16'h000);
    chk("rst_tstate", 16'(trans_state), 16'd0);
    chk("rst_disc", 16'(disconnected_s), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_flags", 16'({crc_en, crc_clr, trans_sent, trans_err}),
        16'd0);
    rst = 1'b0;
    step();
    chk("up_trans", 16'(trans), 16'h3FF);
    chk("up_tstate", 16'(trans_state), 16'd1);
    chk("up_disc", 16'(disconnected_s), 16'd0);

    // read cmd
    start(3'd1, 8'h4E, 7'd3, 64'h0, 8'h0, 16'h1234);
    play(8);
    done();

    // read resp with stuffed data byte
    start(3'd3, 8'h10, 7'd3, 64'hFE1122, 8'h0, 16'hABCD);
    play(12);
    done();

    // write cmd stuffing ADDR and CRC_HI
    start(3'd2, 8'hFE, 7'd2, 64'h5AA5, 8'h0, 16'hFE01);
    play(12);
    done();

    // write resp carries no data
    start(3'd4, 8'h21, 7'd5, 64'hFFFF, 8'h0, 16'h0102);
    play(8);
    done();

    // LT
    start(3'd5, 8'h00, 7'd0, 64'h0, 8'h80, 16'h0000);
    play(3);
    done();

    // reserved selects
    trans_sel = 3'd6;
    step();
    chk("rsv6", 16'({trans, busy, trans_err}), 16'({10'h3FF, 2'b00}));
    trans_sel = 3'd7;
    step();
    chk("rsv7", 16'({trans, busy, trans_err}), 16'({10'h3FF, 2'b00}));
    trans_sel = 3'd0;

    // over-length write cmd
    trans_sel = 3'd2;
    trans_len = 7'(ML + 1);
    step();
    trans_sel = 3'd0;
    chk("err_pulse", 16'(trans_err), 16'd1);
    chk("err_trans", 16'(trans), 16'h3FF);
    chk("err_busy0", 16'(busy), 16'd0);
    step();
    chk("err_clear", 16'(trans_err), 16'd0);
    chk("err_trans2", 16'(trans), 16'h3FF);
    chk("err_busy1", 16'(busy), 16'd0);

    // request while busy is ignored
    start(3'd1, 8'h33, 7'd0, 64'h0, 8'h0, 16'h5555);
    play(2);
    trans_sel = 3'd2; trans_addr = 8'hAA;
    trans_len = 7'd2; trans_data = 64'h9988;
    crc_in = 16'h5555;
    play(5);
    trans_sel = 3'd0;
    play(1);
    done();

    // disconnect mid-DATA
    tdisconnect_tx_min = 1'b0;
    start(3'd2, 8'h01, 7'd4, 64'h44332211, 8'h0, 16'h0000);
    play(5);
    for (int c = 0; c < 3; c++) begin
      chk("pre_disc", 16'(trans), 16'({1'b1, 8'h22, 1'b0}));
      step();
    end
    disconnect_sbtx = 1'b1;
    step();
    sb.delete();
    chk("disc_trans", 16'(trans), 16'h000);
    chk("disc_tstate", 16'(trans_state), 16'd0);
    chk("disc_flag", 16'(disconnected_s), 16'd1);
    chk("disc_busy", 16'(busy), 16'd0);
    chk("disc_sent", 16'(trans_sent), 16'd0);
    step();
    disconnect_sbtx = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("disc_hold", 16'({trans, trans_state, trans_sent}), 16'd0);
    end
    tdisconnect_tx_min = 1'b1;
    step();
    chk("reconn_trans", 16'(trans), 16'h3FF);
    chk("reconn_tstate", 16'(trans_state), 16'd1);
    chk("reconn_flag", 16'(disconnected_s), 16'd0);
    chk("reconn_sent", 16'(trans_sent), 16'd0);

    // mid-transaction reset
    start(3'd5, 8'h00, 7'd0, 64'h0, 8'h3C, 16'h0000);
    play(1);
    rst = 1'b1;
    step();
    sb.delete();
    chk("rst2_trans", 16'(trans), 16'h000);
    chk("rst2_busy", 16'(busy), 16'd0);
    chk("rst2_disc", 16'(disconnected_s), 16'd1);
    rst = 1'b0;
    step();
    chk("rst2_idle", 16'(trans), 16'h3FF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
